// File: rtl/sipo_frame_rx.sv
// Serial frame receiver: start, WIDTH data bits (LSB first), even parity, stop; one-word output buffer with valid/ready.
// Word is presented on the stop-bit edge; frm_err/overrun are single-cycle pulses registered on that same edge.
module sipo_frame_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             si,
  input  logic             en,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             par_err,
  output logic             frm_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             par_q, par_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             frm_q, frm_d;
  logic             ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    frm_d   = 1'b0;
    ovr_d   = 1'b0;

    // Consumer handshake is serviced every edge, independent of the bit strobe.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (!si) begin
            state_d = S_DATA;
            cnt_d   = '0;
          end
        end
        S_DATA: begin
          sr_d  = {si, sr_q[WIDTH-1:1]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = si;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (!si) begin
            frm_d = 1'b1;
          end else if (!valid_q || ready) begin
            // A word consumed on this edge frees the buffer for the new one.
            data_d  = sr_q;
            perr_d  = ^{sr_q, par_q};
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      frm_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      frm_q   <= frm_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign par_err  = perr_q;
  assign frm_err  = frm_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Randomized bench for sipo_frame_rx with a frame-level reference model and decoupled scoreboard monitor.
module tb_sipo_frame_rx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         si;
  logic         en;
  logic         ready;
  logic [W-1:0] data_out;
  logic         valid;
  logic         par_err;
  logic         frm_err;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  // Expected words as {par_err, data}; expected pulses: 0 = framing error, 1 = overrun.
  logic [W:0] wq[$];
  int         evq[$];
  bit         mvalid;
  logic [W:0] cur_exp;
  int         rdy_mode;  // 0: low, 1: high, 2: random, 3: high only on the stop edge
  int         en_mode;   // 0: always 1, 1: alternate 1/0, 2: random gaps

  sipo_frame_rx #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .si(si), .en(en), .data_out(data_out), .valid(valid),
    .ready(ready), .par_err(par_err), .frm_err(frm_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Applies one edge's inputs and advances the frame-level model for that edge.
  task automatic do_edge(input logic si_v, input logic en_v, input logic rdy_v, input bit is_stop);
    bit load;
    si    = si_v;
    en    = en_v;
    ready = rdy_v;
    load  = 1'b0;
    if (en_v && is_stop) begin
      if (!si_v) evq.push_back(0);
      else if (!mvalid || rdy_v) begin
        wq.push_back(cur_exp);
        load = 1'b1;
      end else evq.push_back(1);
    end
    if (load) mvalid = 1'b1;
    else if (mvalid && rdy_v) mvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_rdy(input bit is_stop);
    case (rdy_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return logic'($urandom % 2);
      default: return logic'(is_stop);
    endcase
  endfunction

  task automatic send_frame(input logic [W-1:0] d, input logic pbit, input logic sbit);
    logic [W+2:0] bits;
    cur_exp = {(^d) ^ pbit, d};
    bits    = {sbit, pbit, d, 1'b0};
    for (int k = 0; k < W + 3; k++) begin
      if (en_mode == 2)
        while ($urandom % 4 == 0) do_edge(logic'($urandom % 2), 1'b0, pick_rdy(0), 0);
      do_edge(bits[k], 1'b1, pick_rdy(k == W + 2), k == W + 2);
      if (en_mode == 1) do_edge(logic'($urandom % 2), 1'b0, pick_rdy(0), 0);
    end
  endtask

  task automatic do_reset();
    clr   = 1'b1;
    en    = 1'b1;
    si    = logic'($urandom % 2);
    ready = logic'($urandom % 2);
    wq.delete();
    evq.delete();
    mvalid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_data", 32'(data_out), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_par_err", 32'(par_err), 0);
    chk("rst_frm_err", 32'(frm_err), 0);
    chk("rst_overrun", 32'(overrun), 0);
    clr = 1'b0;
  endtask

  // Scoreboard monitor: inputs settle at posedge+1, so negedge sees the coming edge's handshake.
  always @(negedge clk) begin
    if (clr === 1'b0) begin
      if (valid && ready) begin
        if (wq.size() == 0) chk("word_unexpected", {23'd0, par_err, data_out}, 32'h1ff_ffff);
        else chk("word", {23'd0, par_err, data_out}, 32'(wq.pop_front()));
      end
      if (frm_err) begin
        if (evq.size() == 0) chk("frm_unexpected", 1, 2);
        else chk("frm_pulse", 0, evq.pop_front());
      end
      if (overrun) begin
        if (evq.size() == 0) chk("ovr_unexpected", 1, 2);
        else chk("ovr_pulse", 1, evq.pop_front());
      end
    end
  end

  initial begin
    clr = 1'b1; si = 1'b1; en = 1'b0; ready = 1'b0;
    mvalid = 1'b0; rdy_mode = 0; en_mode = 0; cur_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // 0xA5 good parity, held then consumed
    rdy_mode = 0; en_mode = 0;
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_valid", 32'(valid), 1);
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_perr", 32'(par_err), 0);
    do_edge(1'b1, 1'b1, 1'b1, 0);
    chk("a5_consumed", 32'(valid), 0);

    // 0xA5 with wrong parity bit
    send_frame(8'hA5, 1'b1, 1'b1);
    chk("perr_valid", 32'(valid), 1);
    chk("perr_flag", 32'(par_err), 1);
    do_edge(1'b1, 1'b1, 1'b1, 0);

    // Bad stop bit, then a good frame
    rdy_mode = 1;
    send_frame(8'h3C, 1'b0, 1'b0);
    chk("frm_pulse_hi", 32'(frm_err), 1);
    chk("frm_valid", 32'(valid), 0);
    do_edge(1'b1, 1'b1, 1'b1, 0);
    chk("frm_pulse_lo", 32'(frm_err), 0);
    rdy_mode = 0;
    send_frame(8'h0F, 1'b0, 1'b1);
    chk("after_frm_data", 32'(data_out), 32'h0F);
    do_edge(1'b1, 1'b1, 1'b1, 0);

    // Overrun, then a load on the same edge as consumption
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("ovr_hi", 32'(overrun), 1);
    chk("ovr_data_kept", 32'(data_out), 32'hA5);
    do_edge(1'b1, 1'b1, 1'b0, 0);
    chk("ovr_lo", 32'(overrun), 0);
    rdy_mode = 3;
    send_frame(8'h81, 1'b0, 1'b1);
    chk("swap_data", 32'(data_out), 32'h81);
    chk("swap_valid", 32'(valid), 1);
    chk("swap_no_ovr", 32'(overrun), 0);
    do_edge(1'b1, 1'b1, 1'b1, 0);

    // Strobe on alternate cycles
    rdy_mode = 0; en_mode = 1;
    send_frame(8'hC3, 1'b0, 1'b1);
    chk("alt_en_valid", 32'(valid), 1);
    chk("alt_en_data", 32'(data_out), 32'hC3);
    en_mode = 0;
    do_edge(1'b1, 1'b1, 1'b1, 0);

    // Reset in the middle of a frame, then a frame starting on the first edge after
    rdy_mode = 1;
    do_edge(1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) do_edge(logic'(i % 2), 1'b1, 1'b1, 0);
    do_reset();
    rdy_mode = 0;
    send_frame(8'h11, 1'b0, 1'b1);
    chk("post_rst_data", 32'(data_out), 32'h11);
    chk("post_rst_valid", 32'(valid), 1);
    do_edge(1'b1, 1'b1, 1'b1, 0);

    // Random frames, gaps, strobes, parity and stop faults, and consumer stalls
    rdy_mode = 2;
    for (int n = 0; n < 250; n++) begin
      logic [W-1:0] d;
      d       = W'($urandom);
      en_mode = int'($urandom % 3);
      send_frame(d, (^d) ^ logic'($urandom % 8 == 0), logic'($urandom % 10 != 0));
      for (int g = int'($urandom % 3); g > 0; g--)
        do_edge(1'b1, logic'($urandom % 2), pick_rdy(0), 0);
    end

    rdy_mode = 1;
    repeat (4) do_edge(1'b1, 1'b1, 1'b1, 0);
    chk("drain_words", 32'(wq.size()), 0);
    chk("drain_events", 32'(evq.size()), 0);
    chk("drain_valid", 32'(valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
